piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter width, default 10, giving the number of data bits per word.
REQ-002 Port CLK SHALL be input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 Port RSTn SHALL be input, 1 bit, the reset; reset SHALL be asynchronous and active-low.
REQ-004 Port ENABLE SHALL be input, 1 bit, the shift advance qualifier.
REQ-005 Port LOAD_VALID SHALL be input, 1 bit, meaning the source offers a word on DATA_IN.
REQ-006 Port DATA_IN SHALL be input, width bits, the parallel word to serialize.
REQ-007 Port LOAD_READY SHALL be output, 1 bit, meaning the block can accept a word.
REQ-008 Port SHIFT_OUT SHALL be output, 1 bit, the serial data, MSB first.
REQ-009 Port BUSY SHALL be output, 1 bit, high while a word (or parity bit) is being shifted.
REQ-010 Port DONE SHALL be output, 1 bit, a one-cycle pulse marking the end of a word.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT, PARITY (only when PARITY_EN is defined) and DONE.
REQ-012 In IDLE: LOAD_READY=1, BUSY=0, DONE=0, SHIFT_OUT=0.
REQ-013 A word SHALL be accepted at a rising edge where LOAD_VALID=1 and LOAD_READY=1: DATA_IN captured into the shift register, bit counter cleared, next state SHIFT.
REQ-014 In SHIFT: LOAD_READY=0, BUSY=1, and SHIFT_OUT SHALL equal the shift register MSB, i.e. DATA_IN[width-1] in the first cycle after acceptance.
REQ-015 In SHIFT, each edge with ENABLE=1 and counter < width-1 SHALL shift left by one (zero fill) and increment the counter.
REQ-016 In SHIFT, an edge with ENABLE=0 SHALL hold the register, counter and SHIFT_OUT unchanged.
REQ-017 In SHIFT, an edge with ENABLE=1 and counter == width-1 SHALL go to PARITY if PARITY_EN is defined, otherwise to DONE.
REQ-018 In DONE: DONE=1, BUSY=0, LOAD_READY=0, SHIFT_OUT=0; next state SHALL be IDLE unconditionally after one cycle.
REQ-019 LOAD_VALID outside IDLE SHALL be ignored, and DATA_IN SHALL NOT be sampled.
REQ-020 The counter SHALL be $clog2(width) bits wide, minimum 1, and SHALL never exceed width-1.
REQ-021 Minimum word period with ENABLE held at 1 SHALL be width+2 cycles: width bits, one DONE cycle and one IDLE cycle.

Reset
REQ-022 RSTn=0 SHALL immediately force IDLE, clear the shift register, counter and parity accumulator, and set SHIFT_OUT=0, BUSY=0, DONE=0, LOAD_READY=1.
REQ-023 Reset asserted mid-word SHALL abandon the word with no DONE pulse.
REQ-024 After RSTn rises, the next word SHALL be accepted normally.

Configuration
REQ-025 Macro PISO_SERIALIZER_PARITY_EN SHALL control the optional parity bit.
REQ-026 With the macro defined: after the last data bit, state PARITY SHALL drive SHIFT_OUT = XOR of the accepted word (even parity) with BUSY=1; this state SHALL hold while ENABLE=0 and go to DONE on an edge with ENABLE=1.
REQ-027 With the macro undefined: the PARITY state and parity logic SHALL be absent, and SHIFT goes directly to DONE.

Structure
REQ-028 Package piso_pkg SHALL hold the state enum typedef (state_t) and the default width constant.
REQ-029 Sub-module piso_bit_counter SHALL hold the clear/enable counter with a terminal-count output; the FSM and shift register SHALL stay in piso_serializer.

Verification (width=10, ENABLE=1 unless stated)
REQ-030 Reset check: RSTn=0 -> SHIFT_OUT=0, LOAD_READY=1, BUSY=0, DONE=0 with no clock edge required.
REQ-031 Basic word: load 10'b1011001110 -> SHIFT_OUT = 1,0,1,1,0,0,1,1,1,0 on consecutive cycles; DONE=1 on the 11th cycle; LOAD_READY=1 on the 12th.
REQ-032 Stall: same word, ENABLE=0 for 3 cycles after the 4th bit -> the 4th bit (1) is held for 4 cycles, and DONE comes 3 cycles later than in REQ-031.
REQ-033 Ignored load: LOAD_VALID=1 with 10'h3FF during the 5th bit -> serial sequence unchanged versus REQ-031, LOAD_READY=0 throughout.
REQ-034 Reset mid-word: RSTn pulsed low after the 6th bit -> IDLE with no DONE; a following load of 10'h001 -> nine 0s then a 1, then DONE.
REQ-035 Parity build: 10'b1011001110 -> parity bit 0 as the 11th bit, DONE on the 12th cycle; 10'h001 -> parity bit 1.

Source files
------------

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and constants for the PISO serializer
//
// Purpose : FSM state encoding and default word width.
// Config  : PISO_SERIALIZER_PARITY_EN adds the PARITY state.
// Ports   : none (package).

package piso_pkg;

    localparam int unsigned DEFAULT_WIDTH = 10;

`ifdef PISO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd3
    } state_t;
`endif

    // Bit-counter width: $clog2 of the word width, never below one bit.
    function automatic int unsigned cnt_bits(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - clearable bit counter with terminal-count flag
//
// Purpose : counts shifted bits; saturates at LAST so it never exceeds it.
// Ports   : clk_i   - clock
//           rst_ni  - asynchronous active-low reset (count -> 0)
//           clr_i   - synchronous clear (has priority over en_i)
//           en_i    - advance request; ignored once terminal count is reached
//           tc_o    - high while count == LAST

module piso_bit_counter #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned LAST  = 9
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc_o = (count_q == CNT_W'(LAST));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out word serializer, MSB first
//
// Purpose : accepts a word with a valid/ready handshake in IDLE, shifts it
//           out MSB first qualified by ENABLE, then pulses DONE for one cycle.
// Config  : PISO_SERIALIZER_PARITY_EN appends an even-parity bit after the
//           last data bit (PARITY state).
// Ports   : CLK        - clock, rising edge
//           RSTn       - asynchronous active-low reset
//           ENABLE     - shift advance qualifier
//           LOAD_VALID - source offers a word on DATA_IN
//           DATA_IN    - parallel word (width bits)
//           LOAD_READY - block can accept a word (IDLE only)
//           SHIFT_OUT  - serial data
//           BUSY       - high while data or parity bit is on SHIFT_OUT
//           DONE       - one-cycle end-of-word pulse

module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned width = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             ENABLE,
    input  logic             LOAD_VALID,
    input  logic [width-1:0] DATA_IN,
    output logic             LOAD_READY,
    output logic             SHIFT_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CNT_W = cnt_bits(width);

    state_t           state_q;
    state_t           state_d;
    logic [width-1:0] sreg_q;
    logic [width-1:0] sreg_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;

`ifdef PISO_SERIALIZER_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    // Clear on acceptance; advance only on enabled edges in SHIFT. The
    // counter itself refuses to pass width-1.
    assign cnt_clr = (state_q == ST_IDLE) && LOAD_VALID;
    assign cnt_en  = (state_q == ST_SHIFT) && ENABLE;

    piso_bit_counter #(
        .CNT_W (CNT_W),
        .LAST  (width - 1)
    ) u_bit_counter (
        .clk_i  (CLK),
        .rst_ni (RSTn),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
`ifdef PISO_SERIALIZER_PARITY_EN
        parity_d   = parity_q;
`endif
        LOAD_READY = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        SHIFT_OUT  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                LOAD_READY = 1'b1;
                if (LOAD_VALID) begin
                    sreg_d   = DATA_IN;
`ifdef PISO_SERIALIZER_PARITY_EN
                    parity_d = ^DATA_IN;
`endif
                    state_d  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                BUSY      = 1'b1;
                SHIFT_OUT = sreg_q[width-1];
                if (ENABLE) begin
                    if (cnt_tc) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        sreg_d = sreg_q << 1;
                    end
                end
            end

`ifdef PISO_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                BUSY      = 1'b1;
                SHIFT_OUT = parity_q;
                if (ENABLE) begin
                    state_d = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
